// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifu_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned INST_W     = 32;
    localparam logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000;
    // Byte-offset bits inside one 8-byte fetch line.
    localparam int unsigned LINE_OFF_W = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StOut  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, reads 8-byte lines from instruction
// memory, selects the 32-bit half by pc[2] and hands {pc, inst} to decode.
// Redirects flush in-flight work; a redirected request's response is drained.
// Optional macro IFU_LINE_REUSE_EN: present the upper half of a line straight
// from the latched line instead of re-reading memory.
module ifu_fetch_ctrl #(
    parameter int unsigned     XLEN     = ifu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = ifu_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    input  logic            out_ready
);

    import ifu_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] line_q, line_d;
    logic            discard_q, discard_d;
    logic            fire;
    logic            handshake;
`ifdef IFU_LINE_REUSE_EN
    logic            line_valid_q, line_valid_d;
`endif

    // The request address is registered so a redirect cannot disturb a
    // request that memory has not yet accepted.
    assign imem_req_valid = (state_q == StReq);
    assign imem_req_addr  = req_addr_q;
    assign out_valid      = (state_q == StOut) && !redirect_valid;
    assign out_pc         = pc_q;
    assign out_inst       = pc_q[2] ? line_q[2*INST_W-1:INST_W] : line_q[INST_W-1:0];
    assign fire           = out_valid && out_ready;
    assign handshake      = imem_req_valid && imem_req_ready;

    // Next-state, PC, discard and line-latch decisions.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        line_d     = line_q;
        req_addr_d = req_addr_q;
`ifdef IFU_LINE_REUSE_EN
        line_valid_d = line_valid_q && !redirect_valid;
`endif

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                // The outstanding request cannot be withdrawn, so its
                // response has to be drained after a redirect.
                if (redirect_valid) begin
                    discard_d = 1'b1;
                end
                if (handshake) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_resp_valid) begin
                    if (discard_q || redirect_valid) begin
                        discard_d = 1'b0;
                        state_d   = StReq;
                    end else begin
                        line_d  = imem_resp_data;
                        state_d = StOut;
`ifdef IFU_LINE_REUSE_EN
                        line_valid_d = 1'b1;
`endif
                    end
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                end
            end
            StOut: begin
                if (redirect_valid) begin
                    state_d = StReq;
                end else if (fire) begin
`ifdef IFU_LINE_REUSE_EN
                    // Lower half just consumed: upper half is already latched.
                    state_d = (!pc_q[2] && line_valid_q) ? StOut : StReq;
`else
                    state_d = StReq;
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (fire) begin
            pc_d = pc_q + XLEN'(4);
        end

        // Capture the line address only when a new request begins.
        if ((state_d == StReq) && (state_q != StReq)) begin
            req_addr_d = {pc_d[XLEN-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            req_addr_q <= {RESET_PC[XLEN-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            line_q     <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            line_q     <= line_d;
            discard_q  <= discard_d;
        end
    end

`ifdef IFU_LINE_REUSE_EN
    // Tracks whether the latched line still belongs to the current PC stream.
    always_ff @(posedge clk) begin
        if (!reset) begin
            line_valid_q <= 1'b0;
        end else begin
            line_valid_q <= line_valid_d;
        end
    end
`endif

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Fetch-stage controller upstream of the instruction-word selector/decoder.
- Owns the PC register, issues 8-byte-aligned reads to instruction memory over a req/resp handshake, and picks the 32-bit half by pc[2].
- Presents {pc, inst} to decode with valid/ready. Handles redirects (branch/jump/trap) by flushing in-flight work.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- XLEN, 64, PC and memory data width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset; all state is reset on the clk edge while reset==0
- redirect_valid  in  1  flush and load redirect_pc
- redirect_pc  in  XLEN  new fetch PC
- imem_req_valid  out  1  read request valid
- imem_req_addr  out  XLEN  {pc[63:3],3'b000}
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  read data valid (one cycle pulse)
- imem_resp_data  in  XLEN  8-byte line
- out_valid  out  1  instruction valid to decode
- out_pc  out  XLEN  PC of out_inst
- out_inst  out  32  pc[2] ? data[63:32] : data[31:0]
- out_ready  in  1  decode accepts

Behaviour:
- Reset (reset==0 at posedge):
  - pc=RESET_PC, state=IDLE, discard=0.
  - out_valid=0, imem_req_valid=0, out_pc=RESET_PC, out_inst=0.
- States: IDLE, REQ, WAIT, OUT.
- IDLE: one cycle after reset release -> REQ.
- REQ: imem_req_valid=1, addr from pc.
  - Addr and valid are held stable until imem_req_ready.
  - On handshake -> WAIT.
- WAIT: on imem_resp_valid, latch the line.
  - If discard=0 -> OUT.
  - If discard=1 -> clear discard, drop the data, -> REQ.
- OUT: out_valid=1, data registered.
  - Fire (out_valid & out_ready): pc<=pc+4 (wraps mod 2^64) -> REQ.
  - Without fire, hold all out_* stable.
- Latency: request issues 1 cycle after entering REQ. Response-to-out_valid = 1 cycle. Minimum 3 cycles per instruction with zero-wait memory.
- Redirect (highest priority, any state except reset):
  - pc<=redirect_pc.
  - REQ without handshake this cycle: the request is not withdrawn. The next response is discarded, then a new REQ is issued at redirect_pc.
  - REQ with handshake this cycle: discard=1 -> WAIT.
  - WAIT without resp this cycle: discard=1, stay WAIT.
  - WAIT with resp this cycle: drop the resp -> REQ.
  - OUT: out_valid is masked to 0 combinationally in the redirect cycle. Any out_ready that cycle is not a fire -> REQ.
  - IDLE: load pc, -> REQ.
- Redirect and resp in the same cycle: the resp is always dropped.
- Back-to-back redirects: the last one wins; discard stays set until exactly one response is drained.
- redirect_pc[1:0]!=0: pc is loaded as-is; the fetch address still aligns to 8 bytes. Decode/trap logic flags the misalignment.
- Reset mid-WAIT: state returns to IDLE. The memory side guarantees no orphan response after reset.

Optional Feature:
- Macro IFU_LINE_REUSE_EN.
- Defined:
  - On fire with pc[2]==0, the next pc is in the same line. Skip REQ/WAIT; the upper half is presented from the latched line in the next cycle (OUT -> OUT, out_valid stays 1).
  - Redirect invalidates the latched line.
- Undefined: every instruction issues a fresh memory request.

Decomposition:
- Package ifu_pkg:
  - State enum (IDLE, REQ, WAIT, OUT, 2-bit encoding).
  - XLEN, INST_W=32, RESET_PC default.
  - Line-align helper constant (3 offset bits).
- No sub-module; the half-word select is a single assign inside the block.

Test Plan:
- Reset release, zero-wait memory with out_ready=1 -> first request addr 0x8000_0000. Out_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008. Insts are the low, high, low halves of the lines.
- imem_req_ready low for 5 cycles -> req_valid stays 1 and addr stays constant throughout. No out_valid.
- Redirect to 0x8000_0100 in WAIT, response 2 cycles later -> stale response dropped. Next request addr 0x8000_0100, out_pc=0x8000_0100.
- out_ready low 4 cycles in OUT -> out_valid, out_pc and out_inst held. The fire on cycle 5 advances pc by 4.
- Redirect in OUT with out_ready=1 in the same cycle -> out_valid=0 that cycle. No pc+4 advance. Next fetch at redirect_pc.
- With IFU_LINE_REUSE_EN, zero-wait memory -> out_pc 0x8000_0000 then 0x8000_0004 on consecutive cycles, one memory request per 8-byte line.
